// File: rtl/word_fetch_sequencer_pkg.sv
// Shared types and constants for the operand fetch sequencer.
package fetch_pkg;

    // Sequencer states; FIN reports either Done or Error.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_LOAD_HI = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Operand kinds; the reserved code behaves like a zero-extended byte.
    typedef enum logic [1:0] {
        LEN_BYTE_ZX = 2'b00,
        LEN_BYTE_SX = 2'b01,
        LEN_WORD    = 2'b10,
        LEN_RSVD    = 2'b11
    } len_t;

    // Downstream register function selects.
    localparam logic [2:0] FS_NONE      = 3'b000;
    localparam logic [2:0] FS_ZERO_EXT  = 3'b100;
    localparam logic [2:0] FS_LOW_BYTE  = 3'b101;
    localparam logic [2:0] FS_HIGH_BYTE = 3'b110;
    localparam logic [2:0] FS_SIGN_EXT  = 3'b111;

    // Function select used for the first (low) byte of a transfer.
    function automatic logic [2:0] lo_funsel(input len_t len);
        case (len)
            LEN_BYTE_SX: return FS_SIGN_EXT;
            LEN_WORD:    return FS_LOW_BYTE;
            default:     return FS_ZERO_EXT;
        endcase
    endfunction

endpackage

// File: rtl/word_fetch_sequencer_if.sv
// Byte-wide memory read bus with request/acknowledge handshake.
interface word_fetch_sequencer_if;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [7:0]  MemData;

    // The sequencer issues requests and addresses.
    modport master (output MemReq, output MemAddr, input MemAck, input MemData);
    // The memory answers with ack and data.
    modport slave  (input MemReq, input MemAddr, output MemAck, output MemData);
endinterface

// File: rtl/word_fetch_sequencer_ack_timeout_counter.sv
// Counts unacknowledged request cycles and flags when the wait budget is spent.
module ack_timeout_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    logic [7:0] count;

    // expired is raised during the MAX_WAIT-th waiting cycle so the FSM can
    // abort on the edge that ends it.
    assign expired = (count == 8'(MAX_WAIT - 1));

    // Wait counter: cleared outside request states, saturates once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 8'd1;
        end
    end
endmodule

// File: rtl/word_fetch_sequencer.sv
// Fetches an 8/16-bit operand byte-by-byte from memory and loads it into a
// downstream FunSel register with one or two partial-load commands.
module word_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [15:0]                   Addr,
    input  logic [1:0]                    Len,
    word_fetch_sequencer_if.master        mem,
    output logic [15:0]                   RegI,
    output logic                          RegE,
    output logic [2:0]                    RegFunSel,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Error
);
    state_t state;
    len_t   len_q;
    logic   in_req;
    logic   expired;

    assign in_req = (state == ST_REQ_LO) || (state == ST_REQ_HI);

    // The counter is held clear outside request states, so it restarts at
    // zero on entry to every REQ state.
    ack_timeout_counter #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .clk      (Clock),
        .rst_n    (Reset),
        .clear    (!in_req),
        .count_en (in_req && !mem.MemAck),
        .expired  (expired)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            len_q       <= LEN_BYTE_ZX;
            mem.MemReq  <= 1'b0;
            mem.MemAddr <= '0;
            RegI        <= '0;
            RegE        <= 1'b0;
            RegFunSel   <= FS_NONE;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mem.MemAddr <= Addr;
                        len_q       <= len_t'(Len);
                        mem.MemReq  <= 1'b1;
                        Busy        <= 1'b1;
                        state       <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO, ST_REQ_HI: begin
                    if (mem.MemAck) begin
                        RegI       <= {8'h00, mem.MemData};
                        mem.MemReq <= 1'b0;
                        RegE       <= 1'b1;
                        if (state == ST_REQ_LO) begin
                            RegFunSel <= lo_funsel(len_q);
                            state     <= ST_LOAD_LO;
                        end else begin
                            RegFunSel <= FS_HIGH_BYTE;
                            state     <= ST_LOAD_HI;
                        end
                    end else if (expired) begin
                        mem.MemReq <= 1'b0;
                        Error      <= 1'b1;
                        state      <= ST_FIN;
                    end
                end
                ST_LOAD_LO: begin
                    RegE      <= 1'b0;
                    RegFunSel <= FS_NONE;
                    if (len_q == LEN_WORD) begin
                        // 16-bit address wraps naturally from FFFF to 0000.
                        mem.MemAddr <= mem.MemAddr + 16'd1;
                        mem.MemReq  <= 1'b1;
                        state       <= ST_REQ_HI;
                    end else begin
                        Done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_LOAD_HI: begin
                    RegE      <= 1'b0;
                    RegFunSel <= FS_NONE;
                    Done      <= 1'b1;
                    state     <= ST_FIN;
                end
                ST_FIN: begin
                    Done  <= 1'b0;
                    Error <= 1'b0;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_fetch_sequencer.sv
// Directed bench for word_fetch_sequencer with a wait-state memory model and
// a model of the downstream FunSel register.
module tb_word_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Addr  = 16'h0000;
    logic [1:0]  Len   = 2'b00;
    logic [15:0] RegI;
    logic        RegE;
    logic [2:0]  RegFunSel;
    logic        Busy;
    logic        Done;
    logic        Error;

    word_fetch_sequencer_if mem_if ();

    word_fetch_sequencer #(.MAX_WAIT(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Addr      (Addr),
        .Len       (Len),
        .mem       (mem_if),
        .RegI      (RegI),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // cycle counter
    int cyc = 0;
    always @(posedge Clock) cyc = cyc + 1;

    // memory model
    logic [7:0] mem_arr [0:65535];
    int ack_delay = 0;
    bit ack_en = 1'b1;
    int wait_cnt = 0;
    always @(negedge Clock) begin
        if (mem_if.MemReq && ack_en && wait_cnt >= ack_delay) begin
            mem_if.MemAck  = 1'b1;
            mem_if.MemData = mem_arr[mem_if.MemAddr];
            wait_cnt = 0;
        end else begin
            mem_if.MemAck  = 1'b0;
            mem_if.MemData = 8'h00;
            if (mem_if.MemReq) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    // downstream FunSel register model
    logic [15:0] reg_q = 16'h0000;
    always @(posedge Clock) begin
        if (RegE) begin
            case (RegFunSel)
                3'b100: reg_q = {8'h00, RegI[7:0]};
                3'b101: reg_q = {reg_q[15:8], RegI[7:0]};
                3'b110: reg_q = {RegI[7:0], reg_q[7:0]};
                3'b111: reg_q = {{8{RegI[7]}}, RegI[7:0]};
                default: ;
            endcase
        end
    end

    // event logger
    int          clr_gen = 0;
    int          seen_gen = 0;
    int          n_req, req_cycles, rege_cnt, n_fs, done_cnt, err_cnt, done_cyc, err_cyc;
    int          funsel_bad = 0;
    logic        prev_req = 1'b0;
    logic [15:0] req_addr [0:7];
    logic [2:0]  fs_log   [0:7];
    logic [15:0] regi_log [0:7];
    always @(negedge Clock) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            n_req = 0; req_cycles = 0; rege_cnt = 0; n_fs = 0;
            done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        end
        if (mem_if.MemReq) begin
            req_cycles++;
            if (!prev_req && n_req < 8) begin
                req_addr[n_req] = mem_if.MemAddr;
                n_req++;
            end
        end
        prev_req = mem_if.MemReq;
        if (RegE) begin
            rege_cnt++;
            if (n_fs < 8) begin
                fs_log[n_fs]   = RegFunSel;
                regi_log[n_fs] = RegI;
                n_fs++;
            end
        end
        if (!RegE && RegFunSel != 3'b000) funsel_bad++;
        if (Done)  begin done_cnt++; done_cyc = cyc; end
        if (Error) begin err_cnt++;  err_cyc  = cyc; end
    end

    task automatic clear_log();
        clr_gen++;
        @(negedge Clock);
        #1;
    endtask

    int start_cyc;

    task automatic run_xfer(input logic [15:0] a, input logic [1:0] l);
        bit fin;
        clear_log();
        @(negedge Clock);
        Start = 1'b1; Addr = a; Len = l;
        start_cyc = cyc;
        @(negedge Clock);
        Start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            #1;
            if (!Busy) begin
                fin = 1'b1;
                break;
            end
        end
        chk("xfer_finished", 32'(fin), 32'd1);
    endtask

    initial begin
        mem_arr[16'h0040] = 8'hA5;
        mem_arr[16'hFFFF] = 8'h34;
        mem_arr[16'h0000] = 8'h12;
        mem_arr[16'h1000] = 8'h78;
        mem_arr[16'h1001] = 8'h56;
        mem_arr[16'h2000] = 8'hEE;
        mem_if.MemAck  = 1'b0;
        mem_if.MemData = 8'h00;

        // reset state
        repeat (2) @(negedge Clock);
        #1;
        chk("rst_busy",    32'(Busy), 32'd0);
        chk("rst_done",    32'(Done), 32'd0);
        chk("rst_error",   32'(Error), 32'd0);
        chk("rst_memreq",  32'(mem_if.MemReq), 32'd0);
        chk("rst_memaddr", 32'(mem_if.MemAddr), 32'h0);
        chk("rst_rege",    32'(RegE), 32'd0);
        chk("rst_funsel",  32'(RegFunSel), 32'd0);
        chk("rst_regi",    32'(RegI), 32'h0);
        Reset = 1'b1;

        // zero-extended byte, immediate ack
        ack_delay = 0;
        run_xfer(16'h0040, 2'b00);
        chk("zx_nreq",    32'(n_req), 32'd1);
        chk("zx_addr",    32'(req_addr[0]), 32'h0040);
        chk("zx_rege",    32'(rege_cnt), 32'd1);
        chk("zx_funsel",  32'(fs_log[0]), 32'b100);
        chk("zx_regi",    32'(regi_log[0]), 32'h00A5);
        chk("zx_reg",     32'(reg_q), 32'h00A5);
        chk("zx_lat",     32'(done_cyc - start_cyc), 32'd3);
        chk("zx_done",    32'(done_cnt), 32'd1);
        chk("zx_err",     32'(err_cnt), 32'd0);

        // sign-extended byte
        run_xfer(16'h0040, 2'b01);
        chk("sx_funsel",  32'(fs_log[0]), 32'b111);
        chk("sx_reg",     32'(reg_q), 32'hFFA5);
        chk("sx_lat",     32'(done_cyc - start_cyc), 32'd3);

        // word across the address wrap with two wait cycles per ack
        ack_delay = 2;
        run_xfer(16'hFFFF, 2'b10);
        chk("wd_nreq",    32'(n_req), 32'd2);
        chk("wd_addr0",   32'(req_addr[0]), 32'hFFFF);
        chk("wd_addr1",   32'(req_addr[1]), 32'h0000);
        chk("wd_reqcyc",  32'(req_cycles), 32'd6);
        chk("wd_fs0",     32'(fs_log[0]), 32'b101);
        chk("wd_fs1",     32'(fs_log[1]), 32'b110);
        chk("wd_reg",     32'(reg_q), 32'h1234);
        chk("wd_lat",     32'(done_cyc - start_cyc), 32'd9);
        chk("wd_done",    32'(done_cnt), 32'd1);

        // timeout with ack held low
        ack_en = 1'b0;
        ack_delay = 0;
        run_xfer(16'h0040, 2'b00);
        chk("to_reqcyc",  32'(req_cycles), 32'd4);
        chk("to_err",     32'(err_cnt), 32'd1);
        chk("to_err_lat", 32'(err_cyc - start_cyc), 32'd5);
        chk("to_done",    32'(done_cnt), 32'd0);
        chk("to_rege",    32'(rege_cnt), 32'd0);
        chk("to_busy",    32'(Busy), 32'd0);
        ack_en = 1'b1;
        run_xfer(16'h0040, 2'b00);
        chk("to_restart_done", 32'(done_cnt), 32'd1);
        chk("to_restart_reg",  32'(reg_q), 32'h00A5);

        // busy rejection and reset during LOAD_HI
        ack_delay = 1;
        clear_log();
        @(negedge Clock);
        Start = 1'b1; Addr = 16'h1000; Len = 2'b10;
        start_cyc = cyc;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        chk("rs_in_req_hi",  32'(mem_if.MemReq), 32'd1);
        chk("rs_hi_addr",    32'(mem_if.MemAddr), 32'h1001);
        Start = 1'b1; Addr = 16'h2000; Len = 2'b00;
        @(negedge Clock);
        Start = 1'b0;
        #1;
        chk("rs_ignored_addr", 32'(mem_if.MemAddr), 32'h1001);
        @(negedge Clock);
        #1;
        chk("rs_load_hi_e",  32'(RegE), 32'd1);
        chk("rs_load_hi_fs", 32'(RegFunSel), 32'b110);
        #1;
        Reset = 1'b0;
        #1;
        chk("rs_rege",    32'(RegE), 32'd0);
        chk("rs_funsel",  32'(RegFunSel), 32'd0);
        chk("rs_memreq",  32'(mem_if.MemReq), 32'd0);
        chk("rs_memaddr", 32'(mem_if.MemAddr), 32'h0);
        chk("rs_regi",    32'(RegI), 32'h0);
        chk("rs_busy",    32'(Busy), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
        #1;
        chk("rs_post_busy", 32'(Busy), 32'd0);
        chk("rs_post_done", 32'(done_cnt), 32'd0);
        chk("rs_post_err",  32'(err_cnt), 32'd0);
        chk("rs_nreq",      32'(n_req), 32'd2);
        chk("rs_reg_kept",  32'(reg_q), 32'h0078);

        // reserved length behaves as zero-extend
        ack_delay = 0;
        run_xfer(16'h0040, 2'b11);
        chk("rv_funsel", 32'(fs_log[0]), 32'b100);
        chk("rv_reg",    32'(reg_q), 32'h00A5);
        chk("rv_nreq",   32'(n_req), 32'd1);

        chk("funsel_idle_zero", 32'(funsel_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
